// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between fetch (I) and memory-stage (D) requesters.
// D-side has priority; a wait counter forces an I-side grant after MAX_WAIT consecutive losses.
module mem_port_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 2,
    parameter int MAX_WAIT    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [DATA_WIDTH-1:0] i_addr,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  i_valid,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [2:0]            d_funct3,
    input  logic [DATA_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_valid,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [2:0]            mem_funct3,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  stall_i,
    output logic                  stall_d,
    output logic                  busy
);
    localparam int CYC_W  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    state_t              r_state;
    logic [CYC_W-1:0]    r_cyc;
    logic [WAIT_W-1:0]   r_wait;
    logic                r_win_d;
    logic                w_wait_ok;
    logic                w_d_wins;

    assign w_wait_ok = (r_wait < WAIT_W'(MAX_WAIT));
    assign w_d_wins  = d_req & (w_wait_ok | ~i_req);

    assign stall_i = i_req & ~i_valid;
    assign stall_d = d_req & ~d_valid;
    assign busy    = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_cyc      <= '0;
            r_wait     <= '0;
            r_win_d    <= 1'b0;
            i_valid    <= 1'b0;
            d_valid    <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_funct3 <= 3'b000;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            i_valid <= 1'b0;
            d_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_req | d_req) begin
                        r_state <= S_ACCESS;
                        r_cyc   <= '0;
                        mem_en  <= 1'b1;
                        r_win_d <= w_d_wins;
                        if (w_d_wins) begin
                            mem_we     <= d_we;
                            mem_funct3 <= d_funct3;
                            mem_addr   <= d_addr;
                            mem_wdata  <= d_wdata;
                            // D only beats a waiting I while below MAX_WAIT, so this saturates
                            if (i_req)
                                r_wait <= r_wait + 1'b1;
                        end else begin
                            mem_we     <= 1'b0;
                            mem_funct3 <= 3'b010;
                            mem_addr   <= i_addr;
                            mem_wdata  <= '0;
                            r_wait     <= '0;
                        end
                    end
                end
                S_ACCESS: begin
                    if (r_cyc == CYC_W'(MEM_LATENCY - 1)) begin
                        r_state <= S_DONE;
                        mem_en  <= 1'b0;
                        mem_we  <= 1'b0;
                        if (r_win_d) begin
                            d_rdata <= mem_rdata;
                            d_valid <= 1'b1;
                        end else begin
                            i_rdata <= mem_rdata;
                            i_valid <= 1'b1;
                        end
                    end else begin
                        r_cyc <= r_cyc + 1'b1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the fetch stage (I-side) and the memory stage (D-side) of the 5-stage pipeline.
- Sequences each access over a fixed number of memory cycles and returns read data with a one-cycle valid pulse.
- Produces per-requester stall signals for the hazard unit.
- D-side has priority. A wait counter guarantees I-side forward progress.

Parameters:
- DATA_WIDTH, 32, width of data and address buses.
- MEM_LATENCY, 2, cycles mem_* is held stable per access (>=1).
- MAX_WAIT, 3, consecutive lost I-side arbitrations before I-side is forced to win (>=1).

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-low reset (rst=0 resets on clock edge)
- i_req  in  1  fetch request, held until i_valid
- i_addr  in  DATA_WIDTH  fetch address, stable while i_req
- i_rdata  out  DATA_WIDTH  fetched word, meaningful when i_valid
- i_valid  out  1  one-cycle completion pulse for I-side
- d_req  in  1  load/store request, held until d_valid
- d_we  in  1  1=store
- d_funct3  in  3  access size/sign, passed through to memory
- d_addr  in  DATA_WIDTH  data address
- d_wdata  in  DATA_WIDTH  store data
- d_rdata  out  DATA_WIDTH  load data, meaningful when d_valid
- d_valid  out  1  one-cycle completion pulse for D-side
- mem_en  out  1  memory access active
- mem_we  out  1  memory write enable
- mem_funct3  out  3  size to memory (3'b010 for I-side)
- mem_addr  out  DATA_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data, valid in last access cycle
- stall_i  out  1  i_req & ~i_valid (combinational)
- stall_d  out  1  d_req & ~d_valid (combinational)
- busy  out  1  state != IDLE

Behaviour:

Reset (rst=0 at edge):
- State goes to IDLE; counters clear.
- All registered outputs go to 0: i_valid, d_valid, i_rdata, d_rdata, mem_en, mem_we, mem_funct3, mem_addr, mem_wdata.
- Reset during ACCESS or DONE abandons the transfer: no valid pulse, mem_en drops the next cycle.

FSM states: IDLE, ACCESS, DONE.

IDLE:
- If any request is present, arbitrate and register the winner's address, funct3, we and wdata into mem_* on the edge.
- Go to ACCESS with cyc=0 and mem_en=1.
- I-side requests: mem_we=0, mem_funct3=3'b010, mem_wdata=0.

Arbitration:
- D wins if d_req and wait_cnt<MAX_WAIT.
- Otherwise I wins if i_req.
- Otherwise D wins if d_req.

Wait counter (wait_cnt):
- Increments, saturating at MAX_WAIT, when i_req and d_req are both high and D wins.
- Clears when I wins.
- Unchanged otherwise.

ACCESS:
- mem_* is held constant.
- cyc increments each cycle.
- In the cycle with cyc==MEM_LATENCY-1, mem_rdata is captured into the winner's rdata register; go to DONE with mem_en=0 and mem_we=0.

DONE:
- The winner's valid is 1 for exactly this cycle. The other valid is 0.
- The rdata register holds its value until the next capture for that side.
- Requests are ignored this cycle. Next state is IDLE.

Timing and handshake:
- Latency from req sampled in IDLE to valid is MEM_LATENCY+1 cycles.
- Back-to-back accesses have a 1-cycle IDLE gap, so throughput is one access per MEM_LATENCY+2 cycles.
- Stores also pulse d_valid; d_rdata is then undefined-but-stable (the captured mem_rdata).
- A requester must deassert req, or present a new address, in the cycle after valid. A req still high in IDLE is treated as a new access.
- Inputs changing during ACCESS have no effect, because mem_* is registered.
- A requester deasserting req mid-access does not abort the access; valid still pulses.
- Simultaneous i_req and d_req in IDLE: one grant only. The loser's stall stays high.

Test Plan:
1. MEM_LATENCY=2: i_req=1, i_addr=0x100, mem_rdata=0xDEADBEEF -> mem_en=1 in cycles 1-2 with mem_addr=0x100 and mem_funct3=010; i_valid=1 and i_rdata=0xDEADBEEF in cycle 3; stall_i=1 in cycles 0-2 and 0 in cycle 3.
2. Store: d_req=1, d_we=1, d_addr=0x20, d_wdata=0x55, d_funct3=000 -> mem_we=1 and mem_wdata=0x55 for 2 cycles; d_valid pulses in cycle 3; i_valid=0 throughout.
3. Both requests held continuously, MAX_WAIT=3 -> grant order D, D, D, I, D, D, D, I; wait_cnt clears on each I grant.
4. i_req only, held high past i_valid -> a second access starts in the IDLE cycle after DONE; two i_valid pulses 4 cycles apart.
5. rst=0 driven in the second ACCESS cycle -> next cycle state=IDLE, mem_en=0, busy=0, and no valid pulse ever issued for that access.
6. MEM_LATENCY=1: d_req load at 0x40, mem_rdata=0x1234 -> mem_en high for 1 cycle; d_valid and d_rdata=0x1234 in cycle 2.
